// File: rtl/frame_buffer_axi_vram.sv
// ============================================================================
// Module      : frame_buffer_axi_vram
// Description : AXI4-Lite frame store (byte strobes, SLVERR on out-of-range)
//               with a free-running registered read-only pixel port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_buffer_axi_vram #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 16,
    parameter int DEPTH              = 2400
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic [$clog2(DEPTH)-1:0]          vid_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     vid_data
);

    localparam int c_DW     = C_S_AXI_DATA_WIDTH;
    localparam int c_STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int c_IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int c_VID_W  = $clog2(DEPTH);

    localparam logic [c_IDX_W:0] c_DEPTH_IDX = (c_IDX_W + 1)'(DEPTH);
    localparam logic [c_VID_W:0] c_DEPTH_VID = (c_VID_W + 1)'(DEPTH);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam logic [1:0] c_W_IDLE   = 2'd0;
    localparam logic [1:0] c_W_COMMIT = 2'd1;
    localparam logic [1:0] c_W_RESP   = 2'd2;

    localparam logic       c_R_IDLE = 1'b0;
    localparam logic       c_R_DATA = 1'b1;

    logic [c_DW-1:0]     r_mem [DEPTH];

    logic                r_ready_en;
    logic [1:0]          r_wstate;
    logic                r_rstate;
    logic                r_aw_held;
    logic                r_w_held;
    logic [c_IDX_W-1:0]  r_aw_idx;
    logic [c_DW-1:0]     r_wdata;
    logic [c_STRB_W-1:0] r_wstrb;
    logic [1:0]          r_bresp;
    logic [1:0]          r_rresp;
    logic [c_DW-1:0]     r_rdata;
    logic [c_DW-1:0]     r_vid_data;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;
    logic [c_IDX_W-1:0]  w_ar_idx;
    logic                w_aw_in_range;
    logic                w_ar_in_range;
    logic                w_vid_in_range;
    logic                w_commit;
    logic                w_unused_ok;

    // Protection bits and sub-word address bits carry no meaning for this store.
    assign w_unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign s00_axi_awready = r_ready_en & ~r_aw_held;
    assign s00_axi_wready  = r_ready_en & ~r_w_held;
    assign s00_axi_arready = r_ready_en & (r_rstate == c_R_IDLE) & (r_wstate != c_W_COMMIT);
    assign s00_axi_bvalid  = (r_wstate == c_W_RESP);
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_rvalid  = (r_rstate == c_R_DATA);
    assign s00_axi_rresp   = r_rresp;
    assign s00_axi_rdata   = r_rdata;
    assign vid_data        = r_vid_data;

    assign w_aw_hs        = s00_axi_awvalid & s00_axi_awready;
    assign w_w_hs         = s00_axi_wvalid & s00_axi_wready;
    assign w_ar_hs        = s00_axi_arvalid & s00_axi_arready;
    assign w_ar_idx       = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_aw_in_range  = ({1'b0, r_aw_idx} < c_DEPTH_IDX);
    assign w_ar_in_range  = ({1'b0, w_ar_idx} < c_DEPTH_IDX);
    assign w_vid_in_range = ({1'b0, vid_addr} < c_DEPTH_VID);
    assign w_commit       = (r_wstate == c_W_COMMIT) & w_aw_in_range;

    // Write FSM: AW and W latch independently; commit follows the later capture.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_ready_en <= 1'b0;
            r_wstate   <= c_W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= c_RESP_OKAY;
        end else begin
            r_ready_en <= 1'b1;
            case (r_wstate)
                c_W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_aw_idx  <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= s00_axi_wdata;
                        r_wstrb  <= s00_axi_wstrb;
                    end
                    if ((r_aw_held | w_aw_hs) & (r_w_held | w_w_hs)) begin
                        r_wstate <= c_W_COMMIT;
                    end
                end
                c_W_COMMIT: begin
                    r_bresp  <= w_aw_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
                    r_wstate <= c_W_RESP;
                end
                c_W_RESP: begin
                    if (s00_axi_bready) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_wstate  <= c_W_IDLE;
                    end
                end
                default: r_wstate <= c_W_IDLE;
            endcase
        end
    end

    // AXI memory port, write side; contents deliberately survive reset.
    always_ff @(posedge s00_axi_aclk) begin
        if (w_commit) begin
            for (int i = 0; i < c_STRB_W; i++) begin
                if (r_wstrb[i]) begin
                    r_mem[r_aw_idx[c_VID_W-1:0]][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read FSM; arready is withheld during commit so the shared port is free.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_rstate <= c_R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= c_RESP_OKAY;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate <= c_R_DATA;
                        r_rdata  <= w_ar_in_range ? r_mem[w_ar_idx[c_VID_W-1:0]] : '0;
                        r_rresp  <= w_ar_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
                    end
                end
                c_R_DATA: begin
                    if (s00_axi_rready) begin
                        r_rstate <= c_R_IDLE;
                    end
                end
                default: r_rstate <= c_R_IDLE;
            endcase
        end
    end

    // Pixel port: read-first, so a same-cycle AXI write shows up one cycle later.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_vid_data <= '0;
        end else begin
            r_vid_data <= w_vid_in_range ? r_mem[vid_addr] : '0;
        end
    end

endmodule

`default_nettype wire

// File: doc/frame_buffer_axi_vram.md
# frame_buffer_axi_vram

Parametrised AXI4-Lite video RAM for the frame buffer IP: DEPTH words of dual-port memory. One port is a fully handshaked AXI4-Lite slave with byte strobes, independent AW/W acceptance, back-pressure and error responses. The other is a read-only pixel port for the video timing logic. It replaces the fixed four-register slave as the CPU-visible frame store.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width; must be a multiple of 8.
- C_S_AXI_ADDR_WIDTH, 16, AXI byte-address width.
- DEPTH, 2400, memory words; requires DEPTH <= 2^(C_S_AXI_ADDR_WIDTH-2).
- s00_axi_aclk  in  1  single clock for AXI and video sides.
- s00_axi_areset  in  1  reset; synchronous, active-high.
- s00_axi_awaddr / awprot / awvalid / awready  in/in/in/out  ADDR_W/3/1/1  write address channel; awprot ignored.
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel.
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr / arprot / arvalid / arready  in/in/in/out  ADDR_W/3/1/1  read address channel; arprot ignored.
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  DATA_W/2/1/1  read data channel.
- vid_addr  in  clog2(DEPTH)  pixel-word index.
- vid_data  out  DATA_W  word at vid_addr, registered.

## Operation
- Word index = addr[ADDR_W-1:2]. addr[1:0] is ignored.
- An index below DEPTH is in range. An index of DEPTH or above gets SLVERR (2'b10):
  - writes to out-of-range indexes are dropped;
  - reads from out-of-range indexes return rdata = 0.
- Write FSM:
  - W_IDLE: AW and W are captured independently into holding registers.
    - awready = !aw_held; wready = !w_held.
    - A captured channel drops its ready until the transaction completes.
  - W_COMMIT: entered on the cycle after both channels are held.
    - If in range, a one-cycle memory write is done with per-byte enable wstrb[i] for byte i.
    - wstrb = 0 is a legal no-op that still returns OKAY.
  - W_RESP: bvalid = 1 and bresp is held stable until bready. On that handshake, the held flags clear and the FSM returns to W_IDLE.
- Read FSM:
  - R_IDLE: arready = 1 unless the write FSM is in W_COMMIT. Write has priority on the shared AXI memory port.
  - R_IDLE -> R_DATA on the AR handshake; the memory read is issued that cycle.
  - R_DATA: rvalid = 1; rdata and rresp are held stable until rready. On that handshake, return to R_IDLE.
  - Only one read is outstanding at a time.
- Video port:
  - Always enabled, read-first.
  - If the AXI side writes the same word in the same cycle, vid_data returns the old word.
  - vid_addr >= DEPTH returns 0.
- Reset effects:
  - FSMs go to idle and the holding registers clear.
  - An in-flight response is abandoned.
  - Memory contents are not cleared.

## Timing
- Reset values: awready = wready = arready = 0, bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0, vid_data = 0.
  - The readies are 1 from the first cycle after reset deasserts.
- Write latency, AW and W handshaked together at cycle 0:
  - commit at cycle 1;
  - bvalid at cycle 2;
  - with bready held high, the next AW/W is accepted at cycle 3.
- AW and W arriving in different cycles: commit occurs the cycle after the later handshake.
- Read latency: AR handshake at cycle 0 -> rvalid with data at cycle 1. With rready held high, the next AR is accepted at cycle 2.
- Read after write to the same word:
  - an AR accepted at or after the commit cycle returns the new data;
  - an AR arriving during W_COMMIT stalls one cycle (arready = 0).
- Video: vid_addr sampled at cycle n -> vid_data valid at cycle n+1. Continuous, with no stalls.
- A valid held low by the master never drops a held flag. Ready is never a function of valid on the same channel.

## Test plan
- Sequential words:
  - Stimulus: write 0x1..0x4 to byte addresses 0x0, 0x4, 0x8, 0xC, then read them back.
  - Required: bresp = rresp = OKAY and rdata = 0x1..0x4. bvalid 2 cycles after AW/W; rvalid 1 cycle after AR.
- Byte strobes:
  - Stimulus: write 0xFFFFFFFF to addr 0x10, then 0x00000000 with wstrb = 4'b0101.
  - Required: reads back 0xFF00FF00. wstrb = 0 leaves the word unchanged and returns OKAY.
- Split channels:
  - Stimulus: W (0xA5A5A5A5, addr 0x20) presented 5 cycles before AW.
  - Required: wready low after the W capture; commit the cycle after AW; correct readback.
  - Repeat with AW first.
- Back-pressure and errors:
  - Stimulus: hold bready/rready low for 10 cycles.
  - Required: bvalid/rvalid and data stay stable, and no second AW/AR is accepted.
  - Stimulus: write and read index DEPTH.
  - Required: SLVERR, memory unchanged, rdata = 0.
- Collision:
  - Stimulus: AR to 0x30 presented in the W_COMMIT cycle of a write of 0x12345678 to 0x30.
  - Required: arready low for 1 cycle; read returns 0x12345678.
  - Stimulus: the same commit with vid_addr = 12.
  - Required: vid_data returns the old word that cycle and the new word the next cycle.
- Reset mid-transaction:
  - Stimulus: assert reset while bvalid = 1.
  - Required: bvalid = 0 the next cycle; readies = 1 the cycle after deassertion; previously written words are retained.
